bin2bcd_serial: RTL and testbench

- Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble).
- Processes one input bit per clock, which keeps area small for wide inputs (ADC readings, counters feeding 7-segment drivers).
- Uses a start/ready/done handshake, a registered BCD result and a sticky overflow flag for when the chosen digit count is too small.
- Sits between datapath counters/ALU results and display or decoder blocks.

---
 rtl/bin2bcd_pkg.sv | 29 ++
 rtl/bin2bcd_serial_digit_adj.sv | 17 +
 rtl/bin2bcd_serial.sv | 146 ++++++++++++++
 tb/tb_bin2bcd_serial.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared constants, FSM state type and sizing helper for the serial
// binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Number of BCD digits needed to represent 2^bits - 1 without overflow.
    function automatic int unsigned min_digits(input int unsigned bits);
        logic [127:0] maxv;
        logic [127:0] pow;
        int unsigned  d;
        maxv = (128'd1 << bits) - 128'd1;
        pow  = 128'd10;
        d    = 1;
        for (int unsigned i = 0; i < 38; i++) begin
            if (pow <= maxv) begin
                d   = d + 1;
                pow = pow * 128'd10;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_serial_digit_adj.sv
// Combinational double-dabble cell: a BCD digit of 5 or more gets +3.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    // Add 3 when the digit would become >= 10 after the next doubling.
    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_DIGIT_W'(5)) begin
            digit_o = digit_i + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_serial.sv
// Serial shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Optional macro BIN2BCD_SIGNED_EN: treat binario_in as two's complement,
// convert its magnitude and report the sign on the extra port negativo.
module bin2bcd_serial
    import bin2bcd_pkg::*;
#(
    parameter int BITS_IN = 16,
    parameter int DIGITS  = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BITS_IN-1:0]            binario_in,
    output logic                          ready,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          overflow
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                          negativo
`endif
);

    localparam int CNT_W = (BITS_IN > 2) ? $clog2(BITS_IN) : 1;
    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS_IN - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BITS_IN-1:0] sh_q, sh_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   acc_adj;
    logic               sticky_q, sticky_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic [BITS_IN-1:0] load_val;
`ifdef BIN2BCD_SIGNED_EN
    logic               neg_acc_q, neg_acc_d;
    logic               neg_q, neg_d;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Value loaded into the shift register on the accepting edge.
    always_comb begin
        load_val = binario_in;
`ifdef BIN2BCD_SIGNED_EN
        // BITS_IN-wide unsigned negate keeps the most negative value exact.
        if (binario_in[BITS_IN-1]) begin
            load_val = ~binario_in + BITS_IN'(1);
        end
`endif
    end

    // Next-state logic: accept in IDLE, adjust-and-shift one bit per CONV cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
        neg_acc_d = neg_acc_q;
        neg_d     = neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CONV;
                    sh_d     = load_val;
                    acc_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CNT_LAST;
`ifdef BIN2BCD_SIGNED_EN
                    neg_acc_d = binario_in[BITS_IN-1];
`endif
                end
            end
            CONV: begin
                {acc_d, sh_d} = {acc_adj[ACC_W-2:0], sh_q, 1'b0};
                sticky_d      = sticky_q | acc_adj[ACC_W-1];
                cnt_d         = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    bcd_d   = acc_d;
                    ovf_d   = sticky_d;
                    done_d  = 1'b1;
`ifdef BIN2BCD_SIGNED_EN
                    neg_d   = neg_acc_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            neg_acc_q <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
`ifdef BIN2BCD_SIGNED_EN
            neg_acc_q <= neg_acc_d;
            neg_q     <= neg_d;
`endif
        end
    end

    assign ready    = (state_q == IDLE);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
    assign negativo = neg_q;
`endif

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Self-checking bench for bin2bcd_serial: a 5-digit and a 3-digit instance
// at 16 input bits, checked against an arithmetic divide/modulo model.
module tb_bin2bcd_serial;
    import bin2bcd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start5 = 1'b0, start3 = 1'b0;
    logic [15:0] bin5 = '0, bin3 = '0;
    logic        ready5, done5, ovf5;
    logic        ready3, done3, ovf3;
    logic [19:0] bcd5;
    logic [11:0] bcd3;
`ifdef BIN2BCD_SIGNED_EN
    logic        neg5, neg3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bin2bcd_serial #(.BITS_IN(16), .DIGITS(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .binario_in(bin5),
        .ready(ready5), .done(done5), .bcd_out(bcd5), .overflow(ovf5)
`ifdef BIN2BCD_SIGNED_EN
        , .negativo(neg5)
`endif
    );

    bin2bcd_serial #(.BITS_IN(16), .DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .binario_in(bin3),
        .ready(ready3), .done(done3), .bcd_out(bcd3), .overflow(ovf3)
`ifdef BIN2BCD_SIGNED_EN
        , .negativo(neg3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: decimal digits by division, overflow by magnitude comparison.
    task automatic ref_conv(input logic [15:0] v, input int digits,
                            output logic [19:0] bcd, output logic ovf, output logic neg);
        longint unsigned m, p;
        neg = 1'b0;
        m   = longint'(v);
`ifdef BIN2BCD_SIGNED_EN
        if (v[15]) begin
            neg = 1'b1;
            m   = 65536 - longint'(v);
        end
`endif
        bcd = '0;
        p   = 1;
        for (int k = 0; k < digits; k++) begin
            bcd = bcd | (20'((m / p) % 10) << (4 * k));
            p   = p * 10;
        end
        ovf = (m >= p);
    endtask

    // Waits for done on dut5; lat = cycles after the accept edge, 0 if timed out.
    task automatic wait_done5(output int lat);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done5) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total++;
        if (ready5 !== 1'b1 || done5 !== 1'b0 || bcd5 !== 20'h0 || ovf5 !== 1'b0) begin
            bad++;
            $display("FAIL reset5: ready=%b done=%b bcd=%h ovf=%b, want 1 0 00000 0", ready5, done5, bcd5, ovf5);
        end
        total++;
        if (ready3 !== 1'b1 || done3 !== 1'b0 || bcd3 !== 12'h0 || ovf3 !== 1'b0) begin
            bad++;
            $display("FAIL reset3: ready=%b done=%b bcd=%h ovf=%b, want 1 0 000 0", ready3, done3, bcd3, ovf3);
        end
        rst = 1'b0;
        tick();
        total++;
        if (min_digits(16) !== 5) begin
            bad++;
            $display("FAIL min_digits16: got %0d want 5", min_digits(16));
        end
    endtask

    task automatic test_zero_latency();
        int lat;
        logic busy_ok;
        start5 = 1'b1; bin5 = 16'd0;
        tick();
        start5 = 1'b0;
        busy_ok = 1'b1;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            if (ready5 !== 1'b0) busy_ok = 1'b0;
            tick();
            if (done5) begin
                lat = n;
                break;
            end
        end
        total++;
        if (lat != 16) begin
            bad++;
            $display("FAIL zero_latency: got %0d want 16", lat);
        end
        total++;
        if (!busy_ok) begin
            bad++;
            $display("FAIL zero_busy: ready was %b during conversion, want 0", 1'b1);
        end
        total++;
        if (bcd5 !== 20'h00000 || ovf5 !== 1'b0 || ready5 !== 1'b1) begin
            bad++;
            $display("FAIL zero_result: bcd=%h ovf=%b ready=%b want 00000 0 1", bcd5, ovf5, ready5);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [19:0] eb; logic eo, en;
        start5 = 1'b1; bin5 = 16'd65535;
        tick();
        start5 = 1'b0;
        wait_done5(lat);
        ref_conv(16'd65535, 5, eb, eo, en);
        total++;
        if (lat != 16 || bcd5 !== eb || ovf5 !== eo) begin
            bad++;
            $display("FAIL max_value: lat=%0d bcd=%h ovf=%b want 16 %h %b", lat, bcd5, ovf5, eb, eo);
        end
        // Issue the next start in the done cycle.
        start5 = 1'b1; bin5 = 16'd1234;
        tick();
        start5 = 1'b0;
        total++;
        if (ready5 !== 1'b0 || done5 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: ready=%b done=%b want 0 0", ready5, done5);
        end
        wait_done5(lat);
        total++;
        if (lat != 16 || bcd5 !== 20'h01234 || ovf5 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_result: lat=%0d bcd=%h ovf=%b want 16 01234 0", lat, bcd5, ovf5);
        end
    endtask

    task automatic test_digits3();
        logic [15:0] vals [2];
        logic [19:0] eb; logic eo, en;
        int lat;
        vals[0] = 16'd1234;
        vals[1] = 16'd999;
        for (int i = 0; i < 2; i++) begin
            start3 = 1'b1; bin3 = vals[i];
            tick();
            start3 = 1'b0;
            lat = 0;
            for (int n = 1; n <= 40; n++) begin
                tick();
                if (done3) begin
                    lat = n;
                    break;
                end
            end
            ref_conv(vals[i], 3, eb, eo, en);
            total++;
            if (lat != 16 || bcd3 !== eb[11:0] || ovf3 !== eo) begin
                bad++;
                $display("FAIL digits3_%0d: lat=%0d bcd=%h ovf=%b want 16 %h %b", vals[i], lat, bcd3, ovf3, eb[11:0], eo);
            end
        end
    endtask

    task automatic test_ignore();
        int dones, at;
        start5 = 1'b1; bin5 = 16'd4321;
        tick();
        start5 = 1'b0;
        dones = 0; at = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 3) bin5 = 16'd7;
            start5 = (c == 5);
            tick();
            if (done5) begin
                dones++;
                at = c;
            end
        end
        start5 = 1'b0;
        total++;
        if (dones != 1 || at != 16) begin
            bad++;
            $display("FAIL ignore_done: count=%0d cycle=%0d want 1 16", dones, at);
        end
        total++;
        if (bcd5 !== 20'h04321 || ovf5 !== 1'b0) begin
            bad++;
            $display("FAIL ignore_hold: bcd=%h ovf=%b want 04321 0", bcd5, ovf5);
        end
    endtask

    task automatic test_reset_abort();
        int dones, lat;
        start5 = 1'b1; bin5 = 16'd500;
        tick();
        start5 = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (ready5 !== 1'b1 || done5 !== 1'b0 || bcd5 !== 20'h0 || ovf5 !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: ready=%b done=%b bcd=%h ovf=%b want 1 0 00000 0", ready5, done5, bcd5, ovf5);
        end
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done5) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL abort_nodone: got %0d done pulses want 0", dones);
        end
        start5 = 1'b1; bin5 = 16'd42;
        tick();
        start5 = 1'b0;
        wait_done5(lat);
        total++;
        if (lat != 16 || bcd5 !== 20'h00042) begin
            bad++;
            $display("FAIL abort_restart: lat=%0d bcd=%h want 16 00042", lat, bcd5);
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        logic [19:0] e5, e3; logic o5, o3, n5, n3;
        int lat;
        for (int i = 0; i < 24; i++) begin
            case (i % 4)
                0: v = 16'($urandom_range(0, 999));
                1: v = 16'($urandom_range(99990, 100009) % 65536);
                default: v = 16'($urandom);
            endcase
            ref_conv(v, 5, e5, o5, n5);
            ref_conv(v, 3, e3, o3, n3);
            start5 = 1'b1; start3 = 1'b1; bin5 = v; bin3 = v;
            tick();
            start5 = 1'b0; start3 = 1'b0;
            bin5 = 16'($urandom); bin3 = 16'($urandom);
            wait_done5(lat);
            total++;
            if (lat != 16 || bcd5 !== e5 || ovf5 !== o5) begin
                bad++;
                $display("FAIL rand5 in=%h: lat=%0d bcd=%h ovf=%b want 16 %h %b", v, lat, bcd5, ovf5, e5, o5);
            end
            total++;
            if (done3 !== 1'b1 || bcd3 !== e3[11:0] || ovf3 !== o3) begin
                bad++;
                $display("FAIL rand3 in=%h: done=%b bcd=%h ovf=%b want 1 %h %b", v, done3, bcd3, ovf3, e3[11:0], o3);
            end
`ifdef BIN2BCD_SIGNED_EN
            total++;
            if (neg5 !== n5 || neg3 !== n3) begin
                bad++;
                $display("FAIL rand_neg in=%h: neg5=%b neg3=%b want %b", v, neg5, neg3, n5);
            end
`endif
        end
    endtask

`ifdef BIN2BCD_SIGNED_EN
    task automatic test_signed();
        logic [15:0] vin [3];
        logic [19:0] want [3];
        logic        wneg [3];
        int lat;
        vin[0] = 16'hFB2E; want[0] = 20'h01234; wneg[0] = 1'b1;
        vin[1] = 16'h8000; want[1] = 20'h32768; wneg[1] = 1'b1;
        vin[2] = 16'd77;   want[2] = 20'h00077; wneg[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start5 = 1'b1; bin5 = vin[i];
            tick();
            start5 = 1'b0;
            wait_done5(lat);
            total++;
            if (lat != 16 || bcd5 !== want[i] || neg5 !== wneg[i] || ovf5 !== 1'b0) begin
                bad++;
                $display("FAIL signed_%h: lat=%0d bcd=%h neg=%b ovf=%b want 16 %h %b 0",
                         vin[i], lat, bcd5, neg5, ovf5, want[i], wneg[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_latency();
        test_back_to_back();
        test_digits3();
        test_ignore();
        test_reset_abort();
        test_random();
`ifdef BIN2BCD_SIGNED_EN
        test_signed();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000");
        $fatal(1, "timeout");
    end

endmodule
